// File: rtl/ref_price_pkg.sv
// ref_price_pkg: shared types, defaults and fixed-point helpers for the
// multi-channel reservation-price engine (ref_price_multi).
//
// Contents:
//   *_DEF          default parameter constants
//   fp_t           signed fixed-point word (FRAC_BITS_DEF fractional bits)
//   int_t          unsigned integer price/time word
//   fp_mul_shift   signed fixed-point multiply: (a*b) >>> FRAC, low word kept
//   fp_mul_int     fixed-point times unsigned integer, low word kept
//   s1_t..s4_t     per-stage pipeline payloads
//
// The datapath is sized by these constants. FP_WORD_SIZE, FRAC_BITS and
// DATA_WIDTH on the top level must keep their default values. CHANNELS and
// CH_W are free.
package ref_price_pkg;

  localparam int FP_WORD_SIZE_DEF = 64;
  localparam int FRAC_BITS_DEF    = 32;
  localparam int DATA_WIDTH_DEF   = 32;
  localparam int CHANNELS_DEF     = 8;

  typedef logic signed [FP_WORD_SIZE_DEF-1:0]   fp_t;
  typedef logic signed [2*FP_WORD_SIZE_DEF-1:0] fp_wide_t;
  typedef logic        [DATA_WIDTH_DEF-1:0]     int_t;

  // The arithmetic shift floors toward -inf. The cast back to fp_t keeps
  // the low word, so out-of-range products wrap.
  function automatic fp_t fp_mul_shift(input fp_t a, input fp_t b);
    fp_wide_t prod;
    prod = fp_wide_t'(a) * fp_wide_t'(b);
    return fp_t'(prod >>> FRAC_BITS_DEF);
  endfunction

  // The integer operand carries no fractional bits, so no shift is needed.
  function automatic fp_t fp_mul_int(input fp_t a, input int_t n);
    fp_wide_t prod;
    prod = fp_wide_t'(a) * fp_wide_t'({1'b0, n});
    return fp_t'(prod);
  endfunction

  // S1: inputs captured and config read, sigma squared, tau computed.
  typedef struct packed {
    fp_t  s_fp;
    fp_t  q;
    fp_t  gamma;
    fp_t  sigma2;
    int_t tau;
  } s1_t;

  // S2: a = q*gamma and b = sigma^2*tau.
  typedef struct packed {
    fp_t s_fp;
    fp_t a;
    fp_t b;
  } s2_t;

  // S3: the adjustment term adj = a*b.
  typedef struct packed {
    fp_t s_fp;
    fp_t adj;
  } s3_t;

  // S4: the output register.
  typedef struct packed {
    fp_t  r;
    logic sat;
  } s4_t;

endpackage

// File: rtl/ref_price_cfg_rf.sv
// ref_price_cfg_rf: per-channel register file for risk factor (gamma) and
// terminal time (T). It has one synchronous write port and one asynchronous
// read port. Reads return the pre-write contents in the cycle of a write,
// which gives read-before-write behaviour to a sample accepted in that cycle.
// Out-of-range write channels are ignored. Out-of-range read channels return
// 0.
//
// Ports:
//   i_clk, i_reset             clock, async active-high reset (entries -> 0)
//   i_we, i_wr_ch              write strobe and target channel
//   i_wr_gamma, i_wr_term      write data
//   i_rd_ch                    read channel
//   o_rd_gamma, o_rd_term      read data (combinational)
module ref_price_cfg_rf
  import ref_price_pkg::*;
#(
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_we,
  input  logic [CH_W-1:0] i_wr_ch,
  input  fp_t             i_wr_gamma,
  input  int_t            i_wr_term,
  input  logic [CH_W-1:0] i_rd_ch,
  output fp_t             o_rd_gamma,
  output int_t            o_rd_term
);

  fp_t  gamma_q [CHANNELS];
  fp_t  gamma_d [CHANNELS];
  int_t term_q  [CHANNELS];
  int_t term_d  [CHANNELS];

  // NOTE: every always_comb output is given a default before any branch.
  // The default prevents latch inference on paths that do not assign it.
  always_comb begin
    gamma_d = gamma_q;
    term_d  = term_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (i_we && (i_wr_ch == CH_W'(i))) begin
        gamma_d[i] = i_wr_gamma;
        term_d[i]  = i_wr_term;
      end
    end
  end

  always_comb begin
    o_rd_gamma = '0;
    o_rd_term  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (i_rd_ch == CH_W'(i)) begin
        o_rd_gamma = gamma_q[i];
        o_rd_term  = term_q[i];
      end
    end
  end

  // NOTE: this storage is reset on purpose because the config must read as 0
  // after reset. Pure data arrays would normally be left unreset so they can
  // map to RAM.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      gamma_q <= '{default: '0};
      term_q  <= '{default: '0};
    end else begin
      // NOTE: state uses non-blocking assignment, so all flops update together
      // from values taken before the edge.
      gamma_q <= gamma_d;
      term_q  <= term_d;
    end
  end

endmodule

// File: rtl/ref_price_multi.sv
// ref_price_multi: a 4-stage, multi-channel Avellaneda-Stoikov
// reservation-price engine.
//   r = s - q * gamma * sigma^2 * (T - t)
// It uses signed fixed point. gamma and T come from a per-channel register
// file.
//
// Ports:
//   i_clk, i_reset            clock, async active-high reset
//   i_data_valid/o_data_ready sample handshake; i_channel is the sample tag
//   i_curr_price, i_curr_time unsigned integer s and t
//   i_inventory_state         fixed-point q
//   i_volatility              fixed-point sigma (squared internally)
//   i_cfg_*                   gamma/T register-file write port
//   o_data_valid/i_ready      result handshake
//   o_channel, o_ref_price    result tag and fixed-point r
//   o_sat                     result was clamped (saturating build only)
//   o_chan_err                sticky out-of-range channel flag
//
// Build option: define REF_PRICE_SAT_EN to clamp r to [0, max positive] in
// S4 and to flag clamps on o_sat. Without the macro, S4 wraps and o_sat is 0.
module ref_price_multi
  import ref_price_pkg::*;
#(
  parameter int FP_WORD_SIZE = FP_WORD_SIZE_DEF,
  parameter int FRAC_BITS    = FRAC_BITS_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int CHANNELS     = CHANNELS_DEF,
  parameter int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_data_valid,
  output logic                           o_data_ready,
  input  logic        [CH_W-1:0]         i_channel,
  input  logic        [DATA_WIDTH-1:0]   i_curr_price,
  input  logic signed [FP_WORD_SIZE-1:0] i_inventory_state,
  input  logic        [DATA_WIDTH-1:0]   i_curr_time,
  input  logic signed [FP_WORD_SIZE-1:0] i_volatility,
  input  logic                           i_cfg_valid,
  input  logic        [CH_W-1:0]         i_cfg_channel,
  input  logic signed [FP_WORD_SIZE-1:0] i_cfg_risk_factor,
  input  logic        [DATA_WIDTH-1:0]   i_cfg_terminal_time,
  output logic                           o_data_valid,
  input  logic                           i_ready,
  output logic        [CH_W-1:0]         o_channel,
  output logic signed [FP_WORD_SIZE-1:0] o_ref_price,
  output logic                           o_sat,
  output logic                           o_chan_err
);

  // One extra bit so that CHANNELS itself can be represented in the compare.
  localparam logic [CH_W:0] CHAN_LIMIT = (CH_W+1)'(CHANNELS);

  logic stall;
  logic advance;
  logic accept;
  logic samp_bad;
  logic cfg_bad;

  fp_t  rd_gamma;
  int_t rd_term;

  logic s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic s3_vld_q, s3_vld_d, s4_vld_q, s4_vld_d;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  s3_t  s3_q, s3_d;
  s4_t  s4_q, s4_d;
  logic [CH_W-1:0] ch1_q, ch1_d, ch2_q, ch2_d, ch3_q, ch3_d, ch4_q, ch4_d;
  logic chan_err_q, chan_err_d;

  // Only a full, unaccepted output blocks the pipe, so every stage advances
  // together and bubbles collapse naturally.
  assign stall        = s4_vld_q && !i_ready;
  assign advance      = !stall;
  assign o_data_ready = !stall;
  assign accept       = i_data_valid && o_data_ready;
  assign samp_bad     = {1'b0, i_channel} >= CHAN_LIMIT;
  assign cfg_bad      = {1'b0, i_cfg_channel} >= CHAN_LIMIT;

  ref_price_cfg_rf #(
    .CHANNELS (CHANNELS),
    .CH_W     (CH_W)
  ) u_cfg_rf (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_we       (i_cfg_valid),
    .i_wr_ch    (i_cfg_channel),
    .i_wr_gamma (i_cfg_risk_factor),
    .i_wr_term  (i_cfg_terminal_time),
    .i_rd_ch    (i_channel),
    .o_rd_gamma (rd_gamma),
    .o_rd_term  (rd_term)
  );

  always_comb begin
    s1_vld_d   = s1_vld_q;
    s2_vld_d   = s2_vld_q;
    s3_vld_d   = s3_vld_q;
    s4_vld_d   = s4_vld_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    s3_d       = s3_q;
    s4_d       = s4_q;
    ch1_d      = ch1_q;
    ch2_d      = ch2_q;
    ch3_d      = ch3_q;
    ch4_d      = ch4_q;
    chan_err_d = chan_err_q | (accept && samp_bad) | (i_cfg_valid && cfg_bad);

    if (advance) begin
      // S1: out-of-range samples are consumed here and never become valid.
      s1_vld_d    = accept && !samp_bad;
      ch1_d       = i_channel;
      s1_d.s_fp   = fp_t'(i_curr_price) << FRAC_BITS;
      s1_d.q      = i_inventory_state;
      s1_d.gamma  = rd_gamma;
      s1_d.sigma2 = fp_mul_shift(i_volatility, i_volatility);
      s1_d.tau    = (rd_term > i_curr_time) ? (rd_term - i_curr_time) : '0;

      // S2
      s2_vld_d  = s1_vld_q;
      ch2_d     = ch1_q;
      s2_d.s_fp = s1_q.s_fp;
      s2_d.a    = fp_mul_shift(s1_q.q, s1_q.gamma);
      s2_d.b    = fp_mul_int(s1_q.sigma2, s1_q.tau);

      // S3
      s3_vld_d  = s2_vld_q;
      ch3_d     = ch2_q;
      s3_d.s_fp = s2_q.s_fp;
      s3_d.adj  = fp_mul_shift(s2_q.a, s2_q.b);

      // S4
      s4_vld_d = s3_vld_q;
      ch4_d    = ch3_q;
`ifdef REF_PRICE_SAT_EN
      begin
        // s_fp is a zero-extended price and adj is signed. Two guard bits
        // hold the exact difference, so both clamp limits can be detected.
        logic signed [FP_WORD_SIZE_DEF+1:0] diff;
        logic signed [FP_WORD_SIZE_DEF+1:0] max_pos;
        max_pos = {3'b000, {(FP_WORD_SIZE_DEF-1){1'b1}}};
        diff    = $signed({2'b00, s3_q.s_fp}) -
                  $signed({{2{s3_q.adj[FP_WORD_SIZE_DEF-1]}}, s3_q.adj});
        if (diff < 0) begin
          s4_d.r   = '0;
          s4_d.sat = 1'b1;
        end else if (diff > max_pos) begin
          s4_d.r   = fp_t'(max_pos);
          s4_d.sat = 1'b1;
        end else begin
          s4_d.r   = fp_t'(diff);
          s4_d.sat = 1'b0;
        end
      end
`else
      s4_d.r   = s3_q.s_fp - s3_q.adj;
      s4_d.sat = 1'b0;
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      s3_vld_q   <= 1'b0;
      s4_vld_q   <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      s4_q       <= '0;
      ch1_q      <= '0;
      ch2_q      <= '0;
      ch3_q      <= '0;
      ch4_q      <= '0;
      chan_err_q <= 1'b0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s2_vld_q   <= s2_vld_d;
      s3_vld_q   <= s3_vld_d;
      s4_vld_q   <= s4_vld_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      s4_q       <= s4_d;
      ch1_q      <= ch1_d;
      ch2_q      <= ch2_d;
      ch3_q      <= ch3_d;
      ch4_q      <= ch4_d;
      chan_err_q <= chan_err_d;
    end
  end

  assign o_data_valid = s4_vld_q;
  assign o_channel    = ch4_q;
  assign o_ref_price  = s4_q.r;
  assign o_sat        = s4_q.sat;
  assign o_chan_err   = chan_err_q;

endmodule

// File: tb/tb_ref_price_multi.sv
// Testbench for ref_price_multi. Stimulus pushes hand-computed expected
// results into a scoreboard queue. A monitor process pops entries and
// compares them whenever a result is handed off. Inputs change 1 ns after
// the rising edge. Outputs are sampled on the falling edge.
module tb_ref_price_multi;

  localparam int CH_W = 4;  // wide enough to present channel 8 and above

  typedef struct {
    logic [CH_W-1:0]    ch;
    logic signed [63:0] r;
    logic               sat;
  } exp_t;

  logic               clk;
  logic               rst;
  logic               i_data_valid;
  logic               o_data_ready;
  logic [CH_W-1:0]    i_channel;
  logic [31:0]        i_curr_price;
  logic signed [63:0] i_inventory_state;
  logic [31:0]        i_curr_time;
  logic signed [63:0] i_volatility;
  logic               i_cfg_valid;
  logic [CH_W-1:0]    i_cfg_channel;
  logic signed [63:0] i_cfg_risk_factor;
  logic [31:0]        i_cfg_terminal_time;
  logic               o_data_valid;
  logic               i_ready;
  logic [CH_W-1:0]    o_channel;
  logic signed [63:0] o_ref_price;
  logic               o_sat;
  logic               o_chan_err;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  ref_price_multi #(
    .FP_WORD_SIZE (64),
    .FRAC_BITS    (32),
    .DATA_WIDTH   (32),
    .CHANNELS     (8),
    .CH_W         (CH_W)
  ) dut (
    .i_clk               (clk),
    .i_reset             (rst),
    .i_data_valid        (i_data_valid),
    .o_data_ready        (o_data_ready),
    .i_channel           (i_channel),
    .i_curr_price        (i_curr_price),
    .i_inventory_state   (i_inventory_state),
    .i_curr_time         (i_curr_time),
    .i_volatility        (i_volatility),
    .i_cfg_valid         (i_cfg_valid),
    .i_cfg_channel       (i_cfg_channel),
    .i_cfg_risk_factor   (i_cfg_risk_factor),
    .i_cfg_terminal_time (i_cfg_terminal_time),
    .o_data_valid        (o_data_valid),
    .i_ready             (i_ready),
    .o_channel           (o_channel),
    .o_ref_price         (o_ref_price),
    .o_sat               (o_sat),
    .o_chan_err          (o_chan_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic signed [63:0] fx(input int v);
    logic signed [63:0] t;
    t = v;
    return t <<< 32;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  logic               held_vld = 1'b0;
  logic [CH_W-1:0]    held_ch;
  logic signed [63:0] held_r;
  logic               held_sat;

  always @(negedge clk) begin
    if (rst || !o_data_valid) begin
      held_vld = 1'b0;
    end else if (!i_ready) begin
      if (held_vld) begin
        check("stall_hold_ch", 64'(o_channel), 64'(held_ch));
        check("stall_hold_r", o_ref_price, held_r);
        check("stall_hold_sat", 64'(o_sat), 64'(held_sat));
      end
      held_vld = 1'b1;
      held_ch  = o_channel;
      held_r   = o_ref_price;
      held_sat = o_sat;
    end else begin
      held_vld = 1'b0;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: ch=%0d r=%h, none was required", o_channel, o_ref_price);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_ch", 64'(o_channel), 64'(e.ch));
        check("out_r", o_ref_price, e.r);
        check("out_sat", 64'(o_sat), 64'(e.sat));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int ch, input int price, input logic signed [63:0] q,
                      input logic signed [63:0] sig, input int t,
                      input logic signed [63:0] exp_r, input logic exp_sat, input bit push);
    exp_t e;
    bit   done;
    i_data_valid      = 1'b1;
    i_channel         = CH_W'(ch);
    i_curr_price      = 32'(price);
    i_inventory_state = q;
    i_volatility      = sig;
    i_curr_time       = 32'(t);
    done              = 1'b0;
    for (int g = 0; g < 50 && !done; g++) begin
      @(negedge clk);
      if (o_data_ready) begin
        if (push) begin
          e.ch  = CH_W'(ch);
          e.r   = exp_r;
          e.sat = exp_sat;
          sb.push_back(e);
        end
        done = 1'b1;
      end
      tick();
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    i_data_valid = 1'b0;
  endtask

  task automatic cfg(input int ch, input logic signed [63:0] g, input int term);
    i_cfg_valid         = 1'b1;
    i_cfg_channel       = CH_W'(ch);
    i_cfg_risk_factor   = g;
    i_cfg_terminal_time = 32'(term);
    tick();
    i_cfg_valid = 1'b0;
  endtask

  task automatic drain();
    for (int g = 0; g < 40 && (sb.size() != 0 || o_data_valid); g++) tick();
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, 64'(o_data_valid), 64'd0);
    check({tag, "_ch"}, 64'(o_channel), 64'd0);
    check({tag, "_r"}, o_ref_price, 64'd0);
    check({tag, "_sat"}, 64'(o_sat), 64'd0);
    check({tag, "_err"}, 64'(o_chan_err), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  localparam logic signed [63:0] G_HALF    = 64'sh0000_0000_8000_0000;
  localparam logic signed [63:0] G_QUARTER = 64'sh0000_0000_4000_0000;

  initial begin
    rst                 = 1'b1;
    i_ready             = 1'b1;
    i_data_valid        = 1'b0;
    i_channel           = '0;
    i_curr_price        = '0;
    i_inventory_state   = '0;
    i_curr_time         = '0;
    i_volatility        = '0;
    i_cfg_valid         = 1'b0;
    i_cfg_channel       = '0;
    i_cfg_risk_factor   = '0;
    i_cfg_terminal_time = '0;
    repeat (2) tick();
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(o_data_ready), 64'd1);
    tick();

    // 1. Basic result: 100 - 2*0.5*1*6 = 94.0
    cfg(0, G_HALF, 10);
    send(0, 100, fx(2), fx(1), 4, 64'sh0000005E_00000000, 1'b0, 1'b1);
    idle();
    drain();

    // 2. Negative inventory: 100 - (-0.75*4*2) = 106.0
    cfg(3, G_QUARTER, 10);
    send(3, 100, fx(-3), fx(2), 8, fx(106), 1'b0, 1'b1);
    idle();
    drain();

    // 3. t past T gives tau = 0 and r = s exactly. The same-cycle write of
    //    T = 100 must not be seen; with it r would be 12.0.
    i_cfg_valid         = 1'b1;
    i_cfg_channel       = 4'd0;
    i_cfg_risk_factor   = G_HALF;
    i_cfg_terminal_time = 32'd100;
    send(0, 100, fx(2), fx(1), 12, fx(100), 1'b0, 1'b1);
    i_cfg_valid = 1'b0;
    idle();
    drain();
    cfg(0, G_HALF, 10);

    // 4. Backpressure burst of 6 on channels 0 and 3, with a 3-cycle stall.
    fork
      begin
        send(0, 100, fx(2),  fx(1), 4, fx(94),  1'b0, 1'b1);
        send(3, 100, fx(-3), fx(2), 8, fx(106), 1'b0, 1'b1);
        send(0, 100, fx(2),  fx(1), 6, fx(96),  1'b0, 1'b1);
        send(3, 100, fx(-3), fx(2), 6, fx(112), 1'b0, 1'b1);
        send(0, 100, fx(2),  fx(1), 9, fx(99),  1'b0, 1'b1);
        send(3, 100, fx(-3), fx(2), 9, fx(103), 1'b0, 1'b1);
        idle();
      end
      begin
        for (int g = 0; g < 20 && !o_data_valid; g++) tick();
        check("burst_first_valid", 64'(o_data_valid), 64'd1);
        tick();
        i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("stall_ready_low", 64'(o_data_ready), 64'd0);
          tick();
        end
        i_ready = 1'b1;
      end
    join
    drain();

    // 5. Saturation: 1 - 100*1*1*10 = -999.0
    cfg(5, fx(1), 10);
`ifdef REF_PRICE_SAT_EN
    send(5, 1, fx(100), fx(1), 0, 64'sd0, 1'b1, 1'b1);
`else
    send(5, 1, fx(100), fx(1), 0, fx(-999), 1'b0, 1'b1);
`endif
    idle();
    drain();

    // 6. Reset with three samples in flight; none of them may emerge.
    send(0, 100, fx(2), fx(1), 4, 64'sd0, 1'b0, 1'b0);
    send(3, 100, fx(-3), fx(2), 8, 64'sd0, 1'b0, 1'b0);
    send(0, 100, fx(2), fx(1), 6, 64'sd0, 1'b0, 1'b0);
    idle();
    rst = 1'b1;
    #1;
    check_outputs_zero("midreset");
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_midreset", 64'(o_data_ready), 64'd1);
    tick();
    repeat (6) tick();
    // Config must be back to 0, so gamma = 0 and r = s.
    send(0, 50, fx(2), fx(1), 0, fx(50), 1'b0, 1'b1);
    idle();
    drain();
    check("err_before_bad", 64'(o_chan_err), 64'd0);
    send(8, 100, fx(2), fx(1), 0, 64'sd0, 1'b0, 1'b0);
    idle();
    repeat (8) tick();
    check("err_bad_sample", 64'(o_chan_err), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("err_cleared", 64'(o_chan_err), 64'd0);
    cfg(9, fx(1), 10);
    check("err_bad_cfg", 64'(o_chan_err), 64'd1);
    repeat (4) tick();
    check("sb_final_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ref_price_multi.md
# ref_price_multi

Multi-channel, pipelined Avellaneda–Stoikov reservation-price engine: r = s − q·γ·σ²·(T − t), computed in signed fixed point for up to CHANNELS independent instruments. Each channel's risk factor and terminal time live in an internal register file. Tagged samples flow through a 4-stage pipeline with valid/ready backpressure. The block sits between the market-data/inventory tracker and the quote (spread) generator, and supersedes the single-channel reference-price unit.

## Interface

**Parameters**
- FP_WORD_SIZE, 64: fixed-point word width, two's complement.
- FRAC_BITS, 32: fractional bits of every fixed-point quantity.
- DATA_WIDTH, 32: width of integer price and time inputs.
- CHANNELS, 8: number of instruments, ≥1.
- CH_W, $clog2(CHANNELS) (min 1): channel tag width.

**Ports**
- i_clk  in  1  clock; all logic on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_data_valid  in  1  sample valid.
- o_data_ready  out  1  sample accepted when i_data_valid && o_data_ready.
- i_channel  in  CH_W  sample channel.
- i_curr_price  in  DATA_WIDTH  unsigned integer mid price s.
- i_inventory_state  in  FP_WORD_SIZE  signed fixed-point inventory q.
- i_curr_time  in  DATA_WIDTH  unsigned integer time t.
- i_volatility  in  FP_WORD_SIZE  fixed-point σ; the block squares it.
- i_cfg_valid  in  1  config write strobe.
- i_cfg_channel  in  CH_W  config target.
- i_cfg_risk_factor  in  FP_WORD_SIZE  γ for the target channel.
- i_cfg_terminal_time  in  DATA_WIDTH  T for the target channel.
- o_data_valid  out  1  result valid.
- i_ready  in  1  downstream ready.
- o_channel  out  CH_W  tag of the result.
- o_ref_price  out  FP_WORD_SIZE  fixed-point r.
- o_sat  out  1  result was clamped (see Configuration).
- o_chan_err  out  1  sticky: an out-of-range channel was seen.

## Operation

- Price conversion: s_fp = zero-extended i_curr_price << FRAC_BITS.
- S1, capture and read config:
  - Read γ and T for the sample's channel.
  - τ = T − t when T > t, else 0. τ is an unsigned integer.
  - σ² = (σ·σ) >>> FRAC_BITS.
- S2:
  - a = (q·γ) >>> FRAC_BITS.
  - b = σ²·τ. No shift, because τ is an integer.
- S3: adj = (a·b) >>> FRAC_BITS.
- S4: r = s_fp − adj.
- Product width and truncation:
  - All products use 2·FP_WORD_SIZE-bit signed intermediates.
  - The arithmetic shift rounds toward −∞.
  - The low FP_WORD_SIZE bits are kept (wrap).
- Config register file:
  - γ and T per channel; reset value 0.
  - A write to channel ≥ CHANNELS is ignored and sets o_chan_err.
- Same-cycle config write and sample accept on the same channel: the sample uses the old value (read-before-write).
- Sample with i_channel ≥ CHANNELS:
  - Accepted and dropped; no output is produced.
  - Sets o_chan_err, which stays set until reset.
- Channel tag travels with the data. Results leave in acceptance order.

## Timing

- Latency: 4 cycles from accept to o_data_valid when there is no stall.
- Throughput: 1 sample/cycle.
- Stall condition: stall = o_data_valid && !i_ready.
  - On stall, all stages hold and o_data_ready = 0.
  - o_data_ready is combinational from i_ready and o_data_valid.
- Output stability: o_channel, o_ref_price and o_sat hold while o_data_valid && !i_ready.
- Bubbles: stages carry per-stage valid bits. Invalid stages never assert o_data_valid.
- Reset, asynchronous and legal mid-operation:
  - Pipeline valids clear; in-flight samples are discarded.
  - o_data_valid, o_channel, o_ref_price, o_sat, o_chan_err all 0.
  - Config registers return to 0.
  - o_data_ready = 1 in the first cycle after reset deasserts.

## Configuration

- Macro: REF_PRICE_SAT_EN.
- Defined:
  - S4 saturates r to [0, 2^(FP_WORD_SIZE−1)−1]. Negative or overflowed results are clamped.
  - o_sat = 1 with that result.
- Undefined:
  - S4 is plain two's-complement subtraction and wraps.
  - o_sat is tied to 0.

## Structure

- Package ref_price_pkg holds:
  - fp_t typedef (logic signed [FP_WORD_SIZE-1:0]).
  - fp_mul_shift function (signed multiply, >>> FRAC_BITS, truncate).
  - Stage payload struct.
  - Default parameter constants.
- Sub-module ref_price_cfg_rf: CHANNELS-entry γ/T register file with one write port and one async read port.
- Top level contains the pipeline and the handshake.

## Test plan

All values use FRAC_BITS = 32.

1. Basic result: ch0 γ=0.5, T=10; sample s=100, q=2.0, σ=1.0, t=4 → after 4 cycles, ch0, r=94.0 (0x0000005E_00000000).
2. Negative inventory: ch3 γ=0.25, T=10; s=100, q=−3.0, σ=2.0, t=8 → r=106.0, o_channel=3.
3. Time past terminal: t=12 with T=10 → τ=0, r=s_fp exactly. A same-cycle config write to the same channel must not affect this sample.
4. Backpressure: 6 back-to-back samples on alternating channels, i_ready low for 3 cycles mid-burst → all 6 results emerge in order, unchanged, none lost or duplicated; o_data_ready low during the stall.
5. Saturation: s=1, q=100, γ=1.0, σ=1.0, τ=10.
   - With REF_PRICE_SAT_EN: r=0, o_sat=1.
   - Without: r=−999.0 two's complement, o_sat=0.
6. Reset and errors:
   - Assert i_reset with 3 samples in flight → no output appears; all outputs 0.
   - After release, a channel-8 sample (CHANNELS=8) → no output, o_chan_err=1.
